// File: rtl/b1553_pkg.sv
// Shared types and constants for the 1553 host-side responder and its RAM.
package b1553_pkg;

    localparam int B1553_WORD_W = 16;
    localparam int B1553_MBOX_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_READY   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_t;

    // Access is qualified when selected with exactly one strobe low.
    function automatic logic access_qualified(input logic csn, input logic rdn, input logic wrn);
        return (!csn) && (rdn ^ wrn);
    endfunction

endpackage

// File: rtl/b1553_sp_ram.sv
// Single-port shared RAM with synchronous read and write; only the read
// register is reset, the array itself is not.
module b1553_sp_ram
    import b1553_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [B1553_WORD_W-1:0] wdata,
    output logic [B1553_WORD_W-1:0] rdata
);

    logic [B1553_WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [B1553_WORD_W-1:0] rdata_r;

    // Array write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // Read register; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 16'h0000;
        end else if (rd_en) begin
            rdata_r <= mem[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/b1553_host_responder.sv
// Responder end of the bridge strobe interface: wait states, CORE_BUSY stalls, shared RAM.
// Optional mailbox interrupt on address 0 enabled by B1553_RESP_MAILBOX_INT_EN.
module b1553_host_responder
    import b1553_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter int RECOVER_CYC = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              B1553_CSn,
    input  logic              B1553_RDn,
    input  logic              B1553_WRn,
    input  logic [ADDR_W-1:0] B1553_ADDR,
    input  logic [15:0]       B1553_DIN,
    output logic [15:0]       B1553_DOUT,
    output logic              B1553_RDYn,
    input  logic              CORE_BUSY,
    output logic              PROT_ERR,
    output logic              B1553_INTn
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [3:0] REC_INIT  = 4'(RECOVER_CYC);

    state_t            state_r, state_s;
    logic [3:0]        wcnt_r, wcnt_s;
    logic [3:0]        rcnt_r, rcnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [15:0]       din_r, din_s;
    acc_t              acc_r, acc_s;
    logic              enter_ready_s;
    logic              prot_err_s, prot_err_r;
    logic              ram_rd_s, ram_wr_s;
    logic              rdy_n_r;
    logic              qual_s, both_s;

    assign qual_s = access_qualified(B1553_CSn, B1553_RDn, B1553_WRn);
    assign both_s = (!B1553_CSn) && (!B1553_RDn) && (!B1553_WRn);

    // Next-state, latch and RAM-strobe decode.
    always_comb begin
        state_s       = state_r;
        wcnt_s        = wcnt_r;
        rcnt_s        = rcnt_r;
        addr_s        = addr_r;
        din_s         = din_r;
        acc_s         = acc_r;
        prot_err_s    = 1'b0;
        enter_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (qual_s) begin
                    addr_s = B1553_ADDR;
                    din_s  = B1553_DIN;
                    acc_s  = B1553_RDn ? ACC_WR : ACC_RD;
                    if (WAIT_INIT == 4'd0) begin
                        state_s       = ST_READY;
                        enter_ready_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        wcnt_s  = WAIT_INIT;
                    end
                end else if (both_s) begin
                    prot_err_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (B1553_CSn) begin
                    prot_err_s = 1'b1;
                    rcnt_s     = REC_INIT;
                    state_s    = (REC_INIT == 4'd0) ? ST_IDLE : ST_RECOVER;
                end else if (!CORE_BUSY) begin
                    if (wcnt_r <= 4'd1) begin
                        state_s       = ST_READY;
                        enter_ready_s = 1'b1;
                    end else begin
                        wcnt_s = wcnt_r - 4'd1;
                    end
                end else begin
                    wcnt_s = wcnt_r;
                end
            end
            ST_READY: begin
                if (B1553_CSn) begin
                    rcnt_s  = REC_INIT;
                    state_s = (REC_INIT == 4'd0) ? ST_IDLE : ST_RECOVER;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_RECOVER: begin
                if (rcnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    rcnt_s = rcnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // RAM access happens exactly once, on the edge that enters READY.
        ram_rd_s = enter_ready_s && (acc_s == ACC_RD);
        ram_wr_s = enter_ready_s && (acc_s == ACC_WR);
    end

    // State, counters, latched access and registered outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= ST_IDLE;
            wcnt_r     <= 4'd0;
            rcnt_r     <= 4'd0;
            addr_r     <= '0;
            din_r      <= 16'h0000;
            acc_r      <= ACC_RD;
            rdy_n_r    <= 1'b1;
            prot_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            wcnt_r     <= wcnt_s;
            rcnt_r     <= rcnt_s;
            addr_r     <= addr_s;
            din_r      <= din_s;
            acc_r      <= acc_s;
            rdy_n_r    <= (state_s != ST_READY);
            prot_err_r <= prot_err_s;
        end
    end

    b1553_sp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .rd_en (ram_rd_s),
        .wr_en (ram_wr_s),
        .addr  (addr_s),
        .wdata (din_s),
        .rdata (B1553_DOUT)
    );

`ifdef B1553_RESP_MAILBOX_INT_EN
    logic int_n_r;
    logic mbox_hit_s;

    assign mbox_hit_s = (addr_s == ADDR_W'(B1553_MBOX_ADDR));

    // Mailbox interrupt: write to address 0 sets, read clears, set wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            int_n_r <= 1'b1;
        end else if (ram_wr_s && mbox_hit_s) begin
            int_n_r <= 1'b0;
        end else if (ram_rd_s && mbox_hit_s) begin
            int_n_r <= 1'b1;
        end else begin
            int_n_r <= int_n_r;
        end
    end

    assign B1553_INTn = int_n_r;
`else
    assign B1553_INTn = 1'b1;
`endif

    assign B1553_RDYn = rdy_n_r;
    assign PROT_ERR   = prot_err_r;

endmodule

// File: tb/tb_b1553_host_responder.sv
// Table-driven, scoreboarded bench for b1553_host_responder (WAIT_STATES=2, RECOVER_CYC=1).
module tb_b1553_host_responder;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        B1553_CSn, B1553_RDn, B1553_WRn;
    logic [7:0]  B1553_ADDR;
    logic [15:0] B1553_DIN;
    logic [15:0] B1553_DOUT;
    logic        B1553_RDYn;
    logic        CORE_BUSY;
    logic        PROT_ERR;
    logic        B1553_INTn;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb_q [$];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        int          busy;
        int          lat;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs [7];

    always #5 HCLK = ~HCLK;

    b1553_host_responder #(
        .ADDR_W      (8),
        .WAIT_STATES (2),
        .RECOVER_CYC (1)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .B1553_CSn  (B1553_CSn),
        .B1553_RDn  (B1553_RDn),
        .B1553_WRn  (B1553_WRn),
        .B1553_ADDR (B1553_ADDR),
        .B1553_DIN  (B1553_DIN),
        .B1553_DOUT (B1553_DOUT),
        .B1553_RDYn (B1553_RDYn),
        .CORE_BUSY  (CORE_BUSY),
        .PROT_ERR   (PROT_ERR),
        .B1553_INTn (B1553_INTn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full handshake; flip swaps the strobe type after qualification.
    task automatic access(input bit wr, input logic [7:0] a, input logic [15:0] d,
                          input int busy, input int exp_lat, input logic [15:0] exp_rd,
                          input bit flip);
        int lat;
        bit got;
        logic [15:0] e;
        @(negedge HCLK);
        B1553_CSn  = 1'b0;
        B1553_RDn  = wr;
        B1553_WRn  = !wr;
        B1553_ADDR = a;
        B1553_DIN  = d;
        if (!wr) sb_q.push_back(exp_rd);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 64) begin
            @(posedge HCLK);
            lat++;
            #1;
            if (!B1553_RDYn) begin
                got = 1'b1;
            end else begin
                if (lat == 1 && busy > 0) CORE_BUSY = 1'b1;
                if (lat == 1 + busy) CORE_BUSY = 1'b0;
                if (flip && lat == 1) begin
                    B1553_RDn = !B1553_RDn;
                    B1553_WRn = !B1553_WRn;
                end
            end
        end
        CORE_BUSY = 1'b0;
        chk("latency", got ? lat : -1, exp_lat);
        if (!wr) begin
            e = sb_q.pop_front();
            chk("read_data", B1553_DOUT, e);
        end
        @(negedge HCLK);
        CORE_BUSY = 1'b1;
        @(posedge HCLK);
        #1;
        chk("busy_in_ready", B1553_RDYn, 1'b0);
        @(negedge HCLK);
        CORE_BUSY = 1'b0;
        B1553_CSn = 1'b1;
        B1553_RDn = 1'b1;
        B1553_WRn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("recover_rdyn", B1553_RDYn, 1'b1);
        repeat (2) @(posedge HCLK);
    endtask

    initial begin
        logic exp_int_set;
        int   t;
`ifdef B1553_RESP_MAILBOX_INT_EN
        exp_int_set = 1'b0;
`else
        exp_int_set = 1'b1;
`endif
        HRESETn    = 1'b0;
        B1553_CSn  = 1'b1;
        B1553_RDn  = 1'b1;
        B1553_WRn  = 1'b1;
        B1553_ADDR = 8'h00;
        B1553_DIN  = 16'h0000;
        CORE_BUSY  = 1'b0;

        vecs[0] = '{1'b1, 8'h10, 16'hA5A5, 0, 3, 16'h0000};
        vecs[1] = '{1'b0, 8'h10, 16'h0000, 0, 3, 16'hA5A5};
        vecs[2] = '{1'b1, 8'h20, 16'h1111, 0, 3, 16'h0000};
        vecs[3] = '{1'b0, 8'h20, 16'h0000, 4, 7, 16'h1111};
        vecs[4] = '{1'b1, 8'hFF, 16'hBEEF, 2, 5, 16'h0000};
        vecs[5] = '{1'b0, 8'hFF, 16'h0000, 0, 3, 16'hBEEF};
        vecs[6] = '{1'b0, 8'h10, 16'h0000, 1, 4, 16'hA5A5};

        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_rdyn", B1553_RDYn, 1'b1);
        chk("reset_dout", B1553_DOUT, 16'h0000);
        chk("reset_prot_err", PROT_ERR, 1'b0);
        chk("reset_intn", B1553_INTn, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);

        for (int i = 0; i < 7; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].busy,
                   vecs[i].lat, vecs[i].rd, 1'b0);
        end

        // Both strobes low: single protocol error, no access.
        @(negedge HCLK);
        B1553_CSn = 1'b0;
        B1553_RDn = 1'b0;
        B1553_WRn = 1'b0;
        @(posedge HCLK);
        #1;
        chk("both_prot_err", PROT_ERR, 1'b1);
        chk("both_rdyn", B1553_RDYn, 1'b1);
        @(negedge HCLK);
        B1553_CSn = 1'b1;
        B1553_RDn = 1'b1;
        B1553_WRn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("both_prot_err_end", PROT_ERR, 1'b0);
        repeat (2) @(posedge HCLK);
        access(1'b0, 8'h10, 16'h0000, 0, 3, 16'hA5A5, 1'b0);

        // Aborted write: CSn released during WAIT.
        @(negedge HCLK);
        B1553_CSn  = 1'b0;
        B1553_WRn  = 1'b0;
        B1553_ADDR = 8'h20;
        B1553_DIN  = 16'h1234;
        @(negedge HCLK);
        B1553_CSn = 1'b1;
        B1553_WRn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("abort_prot_err", PROT_ERR, 1'b1);
        chk("abort_rdyn", B1553_RDYn, 1'b1);
        repeat (3) @(posedge HCLK);
        access(1'b0, 8'h20, 16'h0000, 0, 3, 16'h1111, 1'b0);

        // Strobe type flipped during WAIT: latched write still rules.
        access(1'b1, 8'h30, 16'h7777, 0, 3, 16'h0000, 1'b1);
        access(1'b0, 8'h30, 16'h0000, 0, 3, 16'h7777, 1'b0);

        // Mailbox at address 0.
        access(1'b1, 8'h00, 16'h0001, 0, 3, 16'h0000, 1'b0);
        chk("mbox_intn_after_write", B1553_INTn, exp_int_set);
        access(1'b0, 8'h00, 16'h0000, 0, 3, 16'h0001, 1'b0);
        chk("mbox_intn_after_read", B1553_INTn, 1'b1);

        // Asynchronous reset while in READY.
        @(negedge HCLK);
        B1553_CSn  = 1'b0;
        B1553_RDn  = 1'b0;
        B1553_ADDR = 8'h10;
        t = 0;
        while (B1553_RDYn && t < 64) begin
            @(posedge HCLK);
            t++;
            #1;
        end
        chk("rst_pre_rdyn", B1553_RDYn, 1'b0);
        chk("rst_pre_dout", B1553_DOUT, 16'hA5A5);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        chk("rst_async_rdyn", B1553_RDYn, 1'b1);
        chk("rst_async_dout", B1553_DOUT, 16'h0000);
        B1553_CSn = 1'b1;
        B1553_RDn = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);
        access(1'b0, 8'h10, 16'h0000, 0, 3, 16'hA5A5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
